member_set_writer: RTL and testbench
====================================

MEMBER_SET_WRITER -- requirements
Module: member_set_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: element width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of table slots.
REQ-003 SHALL have parameter INIT_COUNT, default 4: slots preloaded after reset, at most DEPTH.
REQ-004 SHALL have parameter INIT_STEP, default 10: preload value step; slot i = i*INIT_STEP, truncated to WIDTH.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request accepted when both valid and ready are high.
REQ-010 req_op  in  1  request operation: 0 = INSERT, 1 = DELETE.
REQ-011 req_data  in  WIDTH  element value.
REQ-012 rsp_valid  out  1  single-cycle completion pulse.
REQ-013 rsp_status  out  2  completion status: 0 = OK, 1 = DUP, 2 = FULL, 3 = NOTFOUND.
REQ-014 table_data  out  DEPTH*WIDTH  flattened slot values; slot i occupies bits [i*WIDTH +: WIDTH].
REQ-015 table_valid  out  DEPTH  per-slot occupied mask.
REQ-016 count  out  $clog2(DEPTH+1)  number of occupied slots.
REQ-017 busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 SHALL implement FSM states INIT, IDLE, SCAN and COMMIT.
REQ-019 INIT SHALL write slot i = i*INIT_STEP and set its valid bit, one slot per cycle for i = 0..INIT_COUNT-1, then go to IDLE; INIT_COUNT=0 SHALL go to IDLE after one cycle.
REQ-020 IDLE SHALL drive req_ready=1; on handshake it SHALL capture op and data, then go to SCAN.
REQ-021 SCAN SHALL compare one slot per cycle (index 0..DEPTH-1) and record the first valid slot equal to the captured data and the lowest invalid slot; after DEPTH cycles it SHALL go to COMMIT.
REQ-022 COMMIT SHALL apply the update, pulse rsp_valid with status for exactly one cycle, and return to IDLE.
REQ-023 req_ready SHALL be 0 in INIT, SCAN and COMMIT; rsp_valid has no backpressure.
REQ-024 Latency: rsp_valid SHALL assert exactly DEPTH+1 cycles after the accepting edge; the next request can be accepted the cycle after rsp_valid.
REQ-025 INSERT with a match SHALL return DUP and leave the table unchanged.
REQ-026 INSERT without a match and with a free slot SHALL write the lowest free slot, set its valid bit, increment count and return OK.
REQ-027 INSERT without a match and no free slot SHALL return FULL and leave the table unchanged.
REQ-028 DELETE with a match SHALL clear that slot's valid bit and data, decrement count and return OK.
REQ-029 DELETE without a match SHALL return NOTFOUND.
REQ-030 table_data, table_valid and count SHALL change only in INIT and COMMIT, so they are stable throughout SCAN.
REQ-031 count SHALL always equal the popcount of table_valid and never exceed DEPTH.

Reset
REQ-032 While rst_n is low, all outputs SHALL immediately take: req_ready=0, rsp_valid=0, rsp_status=0, table_data=0, table_valid=0, count=0, busy=1, with state INIT.
REQ-033 Reset asserted during SCAN or COMMIT SHALL abort the operation with no response; a full re-INIT follows release.

Structure
REQ-034 Package member_set_pkg SHALL hold the op, status and state enums and the status encodings.
REQ-035 SHALL contain no sub-modules; the slot comparator is inline.

Verification
REQ-036 Release reset -> 4 INIT cycles, then slots 0..3 = 0,10,20,30, table_valid=8'h0F, count=4, req_ready=1.
REQ-037 INSERT 20 -> rsp_status=DUP 9 cycles after accept; table unchanged.
REQ-038 INSERT 55 -> OK, slot 4 = 55, table_valid=8'h1F, count=5.
REQ-039 Fill to 8 entries, INSERT 99 -> FULL; DELETE 10 -> OK, slot 1 cleared; INSERT 99 -> slot 1 = 99.
REQ-040 DELETE 77 (absent) -> NOTFOUND; count unchanged.
REQ-041 rst_n low in the 3rd SCAN cycle -> outputs reset immediately, no rsp_valid; re-INIT restores the preload.

Source files
------------

// File: rtl/member_set_pkg.sv
// ----------------------------------------------------------------------------
// member_set_pkg
// Shared types for the member_set_writer block: request operation codes,
// completion status codes and the controller state encoding.
// No ports; imported by member_set_writer and its testbench.
// ----------------------------------------------------------------------------
package member_set_pkg;

    // Request operation carried on req_op
    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    // Completion status encodings driven on rsp_status
    localparam logic [1:0] STATUS_OK_ENC       = 2'd0;
    localparam logic [1:0] STATUS_DUP_ENC      = 2'd1;
    localparam logic [1:0] STATUS_FULL_ENC     = 2'd2;
    localparam logic [1:0] STATUS_NOTFOUND_ENC = 2'd3;

    typedef enum logic [1:0] {
        STATUS_OK       = STATUS_OK_ENC,
        STATUS_DUP      = STATUS_DUP_ENC,
        STATUS_FULL     = STATUS_FULL_ENC,
        STATUS_NOTFOUND = STATUS_NOTFOUND_ENC
    } status_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCAN   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/member_set_writer.sv
// ----------------------------------------------------------------------------
// member_set_writer
// Small set table with INSERT / DELETE requests. After reset the table is
// preloaded (slot i = i*INIT_STEP for i < INIT_COUNT). Each accepted request
// is resolved by a sequential scan over all DEPTH slots, then committed in a
// single cycle with a one-cycle completion pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_op, req_data  operation (0 INSERT, 1 DELETE) and element value
//   rsp_valid         one-cycle completion pulse (no backpressure)
//   rsp_status        OK / DUP / FULL / NOTFOUND
//   table_data        flattened slot values, slot i at [i*WIDTH +: WIDTH]
//   table_valid       per-slot occupied mask
//   count             number of occupied slots
//   busy              high whenever the controller is not IDLE
// ----------------------------------------------------------------------------
module member_set_writer
    import member_set_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int INIT_COUNT = 4,
    parameter int INIT_STEP  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_op,
    input  logic [WIDTH-1:0]             req_data,
    output logic                         rsp_valid,
    output logic [1:0]                   rsp_status,
    output logic [DEPTH*WIDTH-1:0]       table_data,
    output logic [DEPTH-1:0]             table_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e            state;
    state_e            next_state;

    logic [IDX_W-1:0]  init_idx;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  match_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              match_found;
    logic              free_found;
    op_e               op_q;
    logic [WIDTH-1:0]  data_q;

    logic [WIDTH-1:0]  slot_data [DEPTH];
    logic [DEPTH-1:0]  slot_valid;
    logic [CNT_W-1:0]  count_q;

    logic              init_last;
    logic              scan_last;
    logic              slot_hit;
    logic              accept;
    logic              do_insert;
    logic              do_delete;
    logic [WIDTH-1:0]  init_value;

    // With no preload, INIT still lasts exactly one cycle
    assign init_last  = (INIT_COUNT == 0) || (init_idx == IDX_W'(INIT_COUNT - 1));
    assign scan_last  = (scan_idx == IDX_W'(DEPTH - 1));
    assign init_value = WIDTH'(INIT_STEP * int'(init_idx));

    // Inline slot comparator for the slot currently under scan
    assign slot_hit = slot_valid[scan_idx] && (slot_data[scan_idx] == data_q);
    assign accept   = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/response outputs. The commit decision is made
    // here so the status and the table update always agree.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_status = STATUS_OK_ENC;
        busy       = 1'b1;
        do_insert  = 1'b0;
        do_delete  = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_last) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                rsp_valid  = 1'b1;
                next_state = ST_IDLE;
                if (op_q == OP_INSERT) begin
                    if (match_found) begin
                        rsp_status = STATUS_DUP_ENC;
                    end else if (free_found) begin
                        rsp_status = STATUS_OK_ENC;
                        do_insert  = 1'b1;
                    end else begin
                        rsp_status = STATUS_FULL_ENC;
                    end
                end else begin
                    if (match_found) begin
                        rsp_status = STATUS_OK_ENC;
                        do_delete  = 1'b1;
                    end else begin
                        rsp_status = STATUS_NOTFOUND_ENC;
                    end
                end
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase
    end

    // Datapath: preload during INIT, request capture in IDLE, first-match and
    // lowest-free tracking during SCAN, table update on the COMMIT edge.
    // The table only moves in INIT and COMMIT, so it is stable while scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_idx    <= '0;
            scan_idx    <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            op_q        <= OP_INSERT;
            data_q      <= '0;
            slot_valid  <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    if (INIT_COUNT > 0) begin
                        slot_data[init_idx]  <= init_value;
                        slot_valid[init_idx] <= 1'b1;
                        count_q              <= count_q + CNT_W'(1);
                        init_idx             <= init_idx + IDX_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        op_q        <= op_e'(req_op);
                        data_q      <= req_data;
                        scan_idx    <= '0;
                        match_idx   <= '0;
                        free_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (slot_hit && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!slot_valid[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + IDX_W'(1);
                end
                ST_COMMIT: begin
                    if (do_insert) begin
                        slot_data[free_idx]  <= data_q;
                        slot_valid[free_idx] <= 1'b1;
                        count_q              <= count_q + CNT_W'(1);
                    end else if (do_delete) begin
                        slot_data[match_idx]  <= '0;
                        slot_valid[match_idx] <= 1'b0;
                        count_q               <= count_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the slot array onto the table_data bus
    always_comb begin
        table_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            table_data[i*WIDTH +: WIDTH] = slot_data[i];
        end
    end

    assign table_valid = slot_valid;
    assign count       = count_q;

endmodule

// File: tb/tb_member_set_writer.sv
// ----------------------------------------------------------------------------
// tb_member_set_writer
// Directed bench for member_set_writer with default parameters. A behavioural
// set model predicts the status of each request; predictions are queued when
// a request is driven and popped when the completion pulse appears.
// ----------------------------------------------------------------------------
module tb_member_set_writer;
    import member_set_pkg::*;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 8;
    localparam int INIT_COUNT = 4;
    localparam int INIT_STEP  = 10;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_op = 1'b0;
    logic [WIDTH-1:0]      req_data = '0;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [1:0]            rsp_status;
    logic [DEPTH*WIDTH-1:0] table_data;
    logic [DEPTH-1:0]      table_valid;
    logic [3:0]            count;
    logic                  busy;

    int compared   = 0;
    int mismatched = 0;

    logic [1:0]       exp_q [$];
    logic [WIDTH-1:0] m_data [DEPTH];
    logic [DEPTH-1:0] m_valid;
    int               m_count;

    member_set_writer #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .INIT_COUNT (INIT_COUNT),
        .INIT_STEP  (INIT_STEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_status  (rsp_status),
        .table_data  (table_data),
        .table_valid (table_valid),
        .count       (count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i]  = (i < INIT_COUNT) ? WIDTH'(i * INIT_STEP) : '0;
            m_valid[i] = (i < INIT_COUNT);
        end
        m_count = INIT_COUNT;
    endtask

    function automatic logic [1:0] modelApply(input logic op, input logic [WIDTH-1:0] d);
        int hit = -1;
        int free = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_data[i] == d && hit < 0) hit = i;
            if (!m_valid[i] && free < 0) free = i;
        end
        if (op == 1'b0) begin
            if (hit >= 0) return 2'd1;
            if (free < 0) return 2'd2;
            m_data[free]  = d;
            m_valid[free] = 1'b1;
            m_count++;
            return 2'd0;
        end
        if (hit < 0) return 2'd3;
        m_data[hit]  = '0;
        m_valid[hit] = 1'b0;
        m_count--;
        return 2'd0;
    endfunction

    task automatic checkTable(input string tag);
        logic [DEPTH*WIDTH-1:0] packed_exp;
        packed_exp = '0;
        for (int i = 0; i < DEPTH; i++) packed_exp[i*WIDTH +: WIDTH] = m_data[i];
        checkOutput({tag, "_data"}, table_data, packed_exp);
        checkOutput({tag, "_valid"}, table_valid, m_valid);
        checkOutput({tag, "_count"}, count, m_count);
    endtask

    // Counts cycles from reset release until req_ready rises
    task automatic waitInit(input string tag);
        int cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!req_ready && cycles < 50);
        checkOutput({tag, "_init_cycles"}, cycles, INIT_COUNT);
        checkOutput({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] d);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", 1'b0, 1'b1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        exp_q.push_back(modelApply(op, d));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits for the completion pulse, checks latency, status and the table
    task automatic waitResponse(input string tag);
        int cycles = 0;
        logic [1:0] expected;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) checkOutput({tag, "_busy_scan"}, {busy, req_ready}, 2'b10);
        end while (!rsp_valid && cycles < 50);
        checkOutput({tag, "_latency"}, cycles, DEPTH + 1);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 1'b0, 1'b1);
        end else begin
            expected = exp_q.pop_front();
            checkOutput({tag, "_status"}, rsp_status, expected);
        end
        @(negedge clk);
        checkOutput({tag, "_pulse_end"}, rsp_valid, 1'b0);
        checkOutput({tag, "_ready_again"}, req_ready, 1'b1);
        checkTable(tag);
    endtask

    initial begin
        modelReset();

        // Outputs while held in reset
        #3;
        checkOutput("rst_ready", req_ready, 1'b0);
        checkOutput("rst_busy", busy, 1'b1);
        checkOutput("rst_rsp", {rsp_valid, rsp_status}, 3'b000);
        checkOutput("rst_table", {table_valid, table_data}, '0);
        checkOutput("rst_count", count, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitInit("preload");
        checkTable("preload");
        checkOutput("preload_valid_const", table_valid, 8'h0F);
        checkOutput("preload_slot3_const", table_data[31:24], 8'd30);

        applyStimulus(OP_INSERT, 8'd20);
        waitResponse("ins20_dup");

        applyStimulus(OP_INSERT, 8'd55);
        waitResponse("ins55_ok");
        checkOutput("ins55_slot4_const", table_data[39:32], 8'd55);
        checkOutput("ins55_valid_const", table_valid, 8'h1F);

        applyStimulus(OP_INSERT, 8'd60);
        waitResponse("ins60");
        applyStimulus(OP_INSERT, 8'd70);
        waitResponse("ins70");
        applyStimulus(OP_INSERT, 8'd80);
        waitResponse("ins80_fill");
        checkOutput("full_count_const", count, 8);

        applyStimulus(OP_INSERT, 8'd99);
        waitResponse("ins99_full");

        applyStimulus(OP_DELETE, 8'd10);
        waitResponse("del10_ok");
        checkOutput("del10_slot1_const", {table_valid[1], table_data[15:8]}, 9'h000);

        applyStimulus(OP_INSERT, 8'd99);
        waitResponse("ins99_slot1");
        checkOutput("ins99_slot1_const", table_data[15:8], 8'd99);

        applyStimulus(OP_DELETE, 8'd77);
        waitResponse("del77_notfound");

        // Abort a request with reset in its third scan cycle
        applyStimulus(OP_INSERT, 8'd5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready_busy", {req_ready, busy}, 2'b01);
        checkOutput("abort_table", {table_valid, table_data}, '0);
        checkOutput("abort_count", count, 0);
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", rsp_valid, 1'b0);
        end
        rst_n = 1'b1;
        modelReset();
        waitInit("reinit");
        checkTable("reinit");

        applyStimulus(OP_INSERT, 8'd30);
        waitResponse("post_reset_dup");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
